// File: rtl/scr_base_l3_bk_pkg.sv
// L3 bank shared types: D4 request record, default geometry, tag-pipe D4 FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scr_base_l3_bk_pkg;

    // Default bank geometry.
    localparam int WAYS_DEF  = 8;
    localparam int SETS_DEF  = 256;
    localparam int TAG_W_DEF = 28;
    localparam int ID_W_DEF  = 6;

    // Field widths of the resolved-request record. These are sized for the
    // largest configuration the bank supports; narrower instances leave the
    // upper bits at zero.
    localparam int REQ_ID_MAX  = 16;
    localparam int REQ_SET_MAX = 16;
    localparam int REQ_WAY_MAX = 8;

    typedef struct packed {
        logic [REQ_ID_MAX-1:0]  id;
        logic [REQ_SET_MAX-1:0] set;
        logic [REQ_WAY_MAX-1:0] way;
        logic                   hit;
        logic                   evict;
        logic                   err;
    } d4_req_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tp_d4_state_e;

endpackage

// File: rtl/scr_base_l3_plru_tree.sv
// Tree-PLRU helper: victim encode from one set's node bits plus the node bits after an access.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the returned bits are written.
//
// Ports:
//   bits     current node bits of the set (heap order, node 0 is the root)
//   acc_way  way being accessed (hit or allocation)
//   victim   way the tree points at (bit = 0 selects the lower subtree)
//   bits_nxt node bits with every node on acc_way's path pointing away from it
module scr_base_l3_plru_tree #(
    parameter int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS),
    localparam int NODES = WAYS - 1
) (
    input  logic [NODES-1:0] bits,
    input  logic [WAY_W-1:0] acc_way,
    output logic [WAY_W-1:0] victim,
    output logic [NODES-1:0] bits_nxt
);

    // Walk root to leaf following the node bits; each level yields one way
    // bit, MSB first. Children of node n are 2n+1 (lower) and 2n+2 (upper).
    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = bits[node];
            node = 2 * node + 1 + (bits[node] ? 1 : 0);
        end
    end

    // Walk the accessed way's path; each node is set to the opposite half.
    always_comb begin
        int   node;
        logic dir;
        bits_nxt = bits;
        node     = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir            = acc_way[WAY_W-1-lvl];
            bits_nxt[node] = ~dir;
            node           = 2 * node + 1 + (dir ? 1 : 0);
        end
    end

endmodule

// File: rtl/scr_base_l3_bk_tp_d4.sv
// L3 bank tag pipe D4: hit/miss resolve, way select (PLRU victim on full-set miss), tag write, handoff to data pipe.
// Latency: 1 cycle accept -> dp_vld_o when the output register is empty or draining; tag write 1 cycle after accept.
// Backpressure: output register + 1 skid entry; d3_rdy_o drops while the skid entry is occupied.
//
// Ports:
//   clk, rst          bank clock, synchronous active-high reset
//   d3_*              request from D3 with per-way hit/valid vectors and allocate flag
//   dp_*              resolved request to the data pipe (valid/ready)
//   tw_*              tag-array write for allocating misses
//   init_busy_o       PLRU table clear sweep in progress
module scr_base_l3_bk_tp_d4
    import scr_base_l3_bk_pkg::*;
#(
    parameter int WAYS  = WAYS_DEF,
    parameter int SETS  = SETS_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int ID_W  = ID_W_DEF,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             d3_vld_i,
    output logic             d3_rdy_o,
    input  logic [ID_W-1:0]  d3_id_i,
    input  logic [SET_W-1:0] d3_set_i,
    input  logic [TAG_W-1:0] d3_tag_i,
    input  logic [WAYS-1:0]  d3_hit_vec_i,
    input  logic [WAYS-1:0]  d3_way_vld_i,
    input  logic             d3_alloc_i,

    output logic             dp_vld_o,
    input  logic             dp_rdy_i,
    output logic [ID_W-1:0]  dp_id_o,
    output logic [SET_W-1:0] dp_set_o,
    output logic [WAY_W-1:0] dp_way_o,
    output logic             dp_hit_o,
    output logic             dp_evict_o,
    output logic             dp_err_o,

    output logic             tw_vld_o,
    output logic [SET_W-1:0] tw_set_o,
    output logic [WAY_W-1:0] tw_way_o,
    output logic [TAG_W-1:0] tw_tag_o,

    output logic             init_busy_o
);

    localparam int NODES = WAYS - 1;

    // ------------------------------------------------------------------
    // Control FSM: INIT clears one PLRU set per cycle, then RUN forever.
    // ------------------------------------------------------------------
    tp_d4_state_e     state_q, state_d;
    logic [SET_W-1:0] init_cnt;
    logic             init_busy;
    logic             run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_cnt == SET_W'(SETS - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        init_busy = (state_q == INIT);
        run       = (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (init_busy) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake. The skid flag is a flop so d3_rdy_o has no path from
    // dp_rdy_i.
    // ------------------------------------------------------------------
    d4_req_t out_q, sk_q, new_req;
    logic    out_vld, sk_vld;
    logic    accept, drain;

    assign d3_rdy_o = run & ~sk_vld;
    assign accept   = d3_vld_i & d3_rdy_o;
    assign drain    = ~out_vld | dp_rdy_i;

    // ------------------------------------------------------------------
    // Way selection
    // ------------------------------------------------------------------
    logic [WAYS-1:0]  inv_vec;
    logic             any_hit, multi_hit, any_inv;
    logic [WAY_W-1:0] hit_way, inv_way, victim_way, sel_way;
    logic             sel_evict, alloc_miss, plru_upd;
    logic [NODES-1:0] plru_q [SETS];
    logic [NODES-1:0] plru_rd, plru_nxt;

    assign inv_vec   = ~d3_way_vld_i;
    assign any_hit   = |d3_hit_vec_i;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_hit = |(d3_hit_vec_i & (d3_hit_vec_i - 1'b1));
    assign any_inv   = |inv_vec;

    // Lowest set bit: scan high to low so the last match wins.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (d3_hit_vec_i[w]) hit_way = WAY_W'(w);
            if (inv_vec[w])      inv_way = WAY_W'(w);
        end
    end

    assign plru_rd = plru_q[d3_set_i];

    scr_base_l3_plru_tree #(
        .WAYS (WAYS)
    ) u_plru_tree (
        .bits     (plru_rd),
        .acc_way  (sel_way),
        .victim   (victim_way),
        .bits_nxt (plru_nxt)
    );

    always_comb begin
        sel_way   = '0;
        sel_evict = 1'b0;
        if (any_hit) begin
            sel_way = hit_way;
        end else if (d3_alloc_i) begin
            if (any_inv) begin
                sel_way = inv_way;
            end else begin
                sel_way   = victim_way;
                sel_evict = 1'b1;
            end
        end
    end

    assign alloc_miss = ~any_hit & d3_alloc_i;
    // Non-allocating misses leave the replacement state untouched.
    assign plru_upd   = accept & (any_hit | d3_alloc_i);

    always_comb begin
        new_req                 = '0;
        new_req.id[ID_W-1:0]    = d3_id_i;
        new_req.set[SET_W-1:0]  = d3_set_i;
        new_req.way[WAY_W-1:0]  = sel_way;
        new_req.hit             = any_hit;
        new_req.evict           = sel_evict;
        new_req.err             = multi_hit;
    end

    // PLRU table is not reset directly; the INIT sweep clears it. Accepts
    // cannot happen in INIT, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            plru_q[init_cnt] <= '0;
        end else if (plru_upd) begin
            plru_q[d3_set_i] <= plru_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid entry. Accept only happens with the skid
    // empty, so a new request either lands in the output register (when it
    // drains) or parks in the skid entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_q   <= '0;
            sk_vld  <= 1'b0;
            sk_q    <= '0;
        end else if (accept) begin
            if (drain) begin
                out_vld <= 1'b1;
                out_q   <= new_req;
            end else begin
                sk_vld  <= 1'b1;
                sk_q    <= new_req;
            end
        end else if (drain) begin
            if (sk_vld) begin
                out_vld <= 1'b1;
                out_q   <= sk_q;
                sk_vld  <= 1'b0;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign dp_vld_o   = out_vld;
    assign dp_id_o    = out_q.id[ID_W-1:0];
    assign dp_set_o   = out_q.set[SET_W-1:0];
    assign dp_way_o   = out_q.way[WAY_W-1:0];
    assign dp_hit_o   = out_q.hit;
    assign dp_evict_o = out_q.evict;
    assign dp_err_o   = out_q.err;

    // ------------------------------------------------------------------
    // Tag write: one-cycle strobe per allocating miss, not held by dp
    // backpressure. Fields keep the last write between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tw_vld_o <= 1'b0;
            tw_set_o <= '0;
            tw_way_o <= '0;
            tw_tag_o <= '0;
        end else begin
            tw_vld_o <= accept & alloc_miss;
            if (accept & alloc_miss) begin
                tw_set_o <= d3_set_i;
                tw_way_o <= sel_way;
                tw_tag_o <= d3_tag_i;
            end
        end
    end

    assign init_busy_o = init_busy;

endmodule

// File: tb/tb_scr_base_l3_bk_tp_d4.sv
module tb_scr_base_l3_bk_tp_d4;

    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int TAG_W = 28;
    localparam int ID_W  = 6;

    logic        clk;
    logic        rst;
    logic        d3_vld_i;
    logic        d3_rdy_o;
    logic [5:0]  d3_id_i;
    logic [3:0]  d3_set_i;
    logic [27:0] d3_tag_i;
    logic [3:0]  d3_hit_vec_i;
    logic [3:0]  d3_way_vld_i;
    logic        d3_alloc_i;
    logic        dp_vld_o;
    logic        dp_rdy_i;
    logic [5:0]  dp_id_o;
    logic [3:0]  dp_set_o;
    logic [1:0]  dp_way_o;
    logic        dp_hit_o;
    logic        dp_evict_o;
    logic        dp_err_o;
    logic        tw_vld_o;
    logic [3:0]  tw_set_o;
    logic [1:0]  tw_way_o;
    logic [27:0] tw_tag_o;
    logic        init_busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_cnt;
    int bad_cnt;

    scr_base_l3_bk_tp_d4 #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .ID_W  (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d3_vld_i     (d3_vld_i),
        .d3_rdy_o     (d3_rdy_o),
        .d3_id_i      (d3_id_i),
        .d3_set_i     (d3_set_i),
        .d3_tag_i     (d3_tag_i),
        .d3_hit_vec_i (d3_hit_vec_i),
        .d3_way_vld_i (d3_way_vld_i),
        .d3_alloc_i   (d3_alloc_i),
        .dp_vld_o     (dp_vld_o),
        .dp_rdy_i     (dp_rdy_i),
        .dp_id_o      (dp_id_o),
        .dp_set_o     (dp_set_o),
        .dp_way_o     (dp_way_o),
        .dp_hit_o     (dp_hit_o),
        .dp_evict_o   (dp_evict_o),
        .dp_err_o     (dp_err_o),
        .tw_vld_o     (tw_vld_o),
        .tw_set_o     (tw_set_o),
        .tw_way_o     (tw_way_o),
        .tw_tag_o     (tw_tag_o),
        .init_busy_o  (init_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] id, input logic [3:0] set,
                         input logic [27:0] tag, input logic [3:0] hv,
                         input logic [3:0] wv, input logic al);
        d3_vld_i     = v;
        d3_id_i      = id;
        d3_set_i     = set;
        d3_tag_i     = tag;
        d3_hit_vec_i = hv;
        d3_way_vld_i = wv;
        d3_alloc_i   = al;
    endtask

    // One clock: inputs driven at the falling edge take effect at the rising
    // edge; outputs are sampled at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count falling edges with init_busy_o high (bounded), and how many of
    // those showed any ready/valid/strobe activity.
    task automatic count_init(output int n, output int bad);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 40 && init_busy_o; i++) begin
            n++;
            if (d3_rdy_o || dp_vld_o || tw_vld_o) bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst      = 1'b1;
        dp_rdy_i = 1'b1;
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);

        // ---- 1. reset and INIT sweep ----
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy",   init_busy_o, 1'b1);
        check("rst_rdy",    d3_rdy_o,    1'b0);
        check("rst_dp_vld", dp_vld_o,    1'b0);
        check("rst_tw_vld", tw_vld_o,    1'b0);
        check("rst_dp_id",  dp_id_o,     6'd0);
        check("rst_tw_tag", tw_tag_o,    28'h0);
        rst = 1'b0;
        count_init(busy_cnt, bad_cnt);
        check("init_cycles", busy_cnt, 16);
        check("init_quiet",  bad_cnt,  0);
        check("run_rdy",     d3_rdy_o, 1'b1);

        // ---- 2. single hit ----
        drive(1'b1, 6'd1, 4'd3, 28'h1234567, 4'b0100, 4'b1111, 1'b0);
        step();
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        check("hit_vld",   dp_vld_o,   1'b1);
        check("hit_id",    dp_id_o,    6'd1);
        check("hit_set",   dp_set_o,   4'd3);
        check("hit_way",   dp_way_o,   2'd2);
        check("hit_hit",   dp_hit_o,   1'b1);
        check("hit_evict", dp_evict_o, 1'b0);
        check("hit_err",   dp_err_o,   1'b0);
        check("hit_tw",    tw_vld_o,   1'b0);
        step();
        check("hit_drained", dp_vld_o, 1'b0);

        // ---- 3. three back-to-back allocating misses, set full ----
        drive(1'b1, 6'd2, 4'd5, 28'hA000001, 4'b0000, 4'b1111, 1'b1);
        step();
        check("v0_way",    dp_way_o,   2'd0);
        check("v0_evict",  dp_evict_o, 1'b1);
        check("v0_hit",    dp_hit_o,   1'b0);
        check("v0_tw",     tw_vld_o,   1'b1);
        check("v0_tw_way", tw_way_o,   2'd0);
        check("v0_tw_set", tw_set_o,   4'd5);
        check("v0_tw_tag", tw_tag_o,   28'hA000001);
        drive(1'b1, 6'd3, 4'd5, 28'hA000002, 4'b0000, 4'b1111, 1'b1);
        step();
        check("v1_id",     dp_id_o,    6'd3);
        check("v1_way",    dp_way_o,   2'd2);
        check("v1_evict",  dp_evict_o, 1'b1);
        check("v1_tw",     tw_vld_o,   1'b1);
        check("v1_tw_way", tw_way_o,   2'd2);
        check("v1_tw_tag", tw_tag_o,   28'hA000002);
        drive(1'b1, 6'd4, 4'd5, 28'hA000003, 4'b0000, 4'b1111, 1'b1);
        step();
        check("v2_way",    dp_way_o,   2'd1);
        check("v2_evict",  dp_evict_o, 1'b1);
        check("v2_tw",     tw_vld_o,   1'b1);
        check("v2_tw_way", tw_way_o,   2'd1);
        check("v2_tw_tag", tw_tag_o,   28'hA000003);
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        step();
        check("v_tw_pulse", tw_vld_o, 1'b0);
        check("v_tw_hold",  tw_way_o, 2'd1);
        check("v_dp_idle",  dp_vld_o, 1'b0);

        // ---- 4. invalid-way fill, multi-hit, non-allocating miss ----
        drive(1'b1, 6'd5, 4'd7, 28'hB000004, 4'b0000, 4'b1011, 1'b1);
        step();
        check("inv_way",    dp_way_o,   2'd2);
        check("inv_evict",  dp_evict_o, 1'b0);
        check("inv_tw",     tw_vld_o,   1'b1);
        check("inv_tw_way", tw_way_o,   2'd2);
        check("inv_tw_set", tw_set_o,   4'd7);
        drive(1'b1, 6'd6, 4'd7, 28'hB000005, 4'b0110, 4'b1111, 1'b0);
        step();
        check("mh_way",     dp_way_o,   2'd1);
        check("mh_hit",     dp_hit_o,   1'b1);
        check("mh_err",     dp_err_o,   1'b1);
        check("mh_tw",      tw_vld_o,   1'b0);
        check("mh_tw_hold", tw_tag_o,   28'hB000004);
        drive(1'b1, 6'd7, 4'd9, 28'hB000006, 4'b0000, 4'b1111, 1'b0);
        step();
        check("na_way",   dp_way_o,   2'd0);
        check("na_hit",   dp_hit_o,   1'b0);
        check("na_evict", dp_evict_o, 1'b0);
        check("na_err",   dp_err_o,   1'b0);
        check("na_tw",    tw_vld_o,   1'b0);
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        step();

        // ---- 5. backpressure and skid ordering ----
        dp_rdy_i = 1'b0;
        drive(1'b1, 6'd10, 4'd1, 28'hC000001, 4'b0001, 4'b1111, 1'b0);
        step();
        check("bp_vld0", dp_vld_o, 1'b1);
        check("bp_id0",  dp_id_o,  6'd10);
        check("bp_rdy0", d3_rdy_o, 1'b1);
        drive(1'b1, 6'd11, 4'd1, 28'hC000002, 4'b0001, 4'b1111, 1'b0);
        step();
        check("bp_full_rdy", d3_rdy_o, 1'b0);
        check("bp_hold_id",  dp_id_o,  6'd10);
        drive(1'b1, 6'd12, 4'd1, 28'hC000003, 4'b0001, 4'b1111, 1'b0);
        step();
        check("bp_stall_rdy", d3_rdy_o, 1'b0);
        check("bp_stall_id",  dp_id_o,  6'd10);
        dp_rdy_i = 1'b1;
        step();
        check("bp_out1_vld", dp_vld_o, 1'b1);
        check("bp_out1_id",  dp_id_o,  6'd11);
        check("bp_reopen",   d3_rdy_o, 1'b1);
        step();
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        check("bp_out2_vld", dp_vld_o, 1'b1);
        check("bp_out2_id",  dp_id_o,  6'd12);
        step();
        check("bp_empty", dp_vld_o, 1'b0);

        // ---- 6. reset with output and skid occupied ----
        dp_rdy_i = 1'b0;
        drive(1'b1, 6'd20, 4'd2, 28'hD000001, 4'b0001, 4'b1111, 1'b0);
        step();
        drive(1'b1, 6'd21, 4'd2, 28'hD000002, 4'b0001, 4'b1111, 1'b0);
        step();
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        check("pre_rst_full", d3_rdy_o, 1'b0);
        check("pre_rst_vld",  dp_vld_o, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_vld",  dp_vld_o,    1'b0);
        check("mid_rst_busy", init_busy_o, 1'b1);
        check("mid_rst_tw",   tw_vld_o,    1'b0);
        check("mid_rst_rdy",  d3_rdy_o,    1'b0);
        rst      = 1'b0;
        dp_rdy_i = 1'b1;
        count_init(busy_cnt, bad_cnt);
        check("reinit_cycles", busy_cnt, 16);
        check("reinit_quiet",  bad_cnt,  0);
        check("reinit_drop",   dp_vld_o, 1'b0);
        // Set 5 was left pointing at way 3; a cleared tree points at way 0.
        drive(1'b1, 6'd30, 4'd5, 28'hE000001, 4'b0000, 4'b1111, 1'b1);
        step();
        drive(1'b0, 6'd0, 4'd0, 28'h0, 4'b0000, 4'b0000, 1'b0);
        check("reinit_plru_way", dp_way_o, 2'd0);
        check("reinit_plru_id",  dp_id_o,  6'd30);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scr_base_l3_bk_tp_d4.md
Name: scr_base_l3_bk_tp_d4

Overview:
L3 bank tag pipe D4 stage. It sits directly downstream of D3 and consumes D3's per-way tag-compare result. It resolves hit/miss, selects the target way (tree-PLRU victim on miss), and issues the tag-array write for allocating misses. It then hands a resolved request to the bank data pipe through a valid/ready interface with a 2-entry skid buffer.

Parameters:
WAYS, 8, associativity; power of 2, >=2
SETS, 256, sets per bank; power of 2
TAG_W, 28, tag width
ID_W, 6, request id width
WAY_W = $clog2(WAYS), SET_W = $clog2(SETS) are derived localparams, not overridable.

Ports:
clk  in  1  bank clock
rst  in  1  synchronous reset, active-high
d3_vld_i  in  1  D3 request valid
d3_rdy_o  out  1  D4 can accept
d3_id_i  in  ID_W  request id
d3_set_i  in  SET_W  set index
d3_tag_i  in  TAG_W  request tag
d3_hit_vec_i  in  WAYS  per-way tag match (valid-qualified)
d3_way_vld_i  in  WAYS  per-way line valid
d3_alloc_i  in  1  allocate on miss
dp_vld_o  out  1  resolved request valid
dp_rdy_i  in  1  data pipe ready
dp_id_o  out  ID_W  id
dp_set_o  out  SET_W  set
dp_way_o  out  WAY_W  selected way
dp_hit_o  out  1  hit
dp_evict_o  out  1  victim valid, writeback required
dp_err_o  out  1  multi-hit detected
tw_vld_o  out  1  tag write strobe
tw_set_o  out  SET_W  tag write set
tw_way_o  out  WAY_W  tag write way
tw_tag_o  out  TAG_W  tag write data
init_busy_o  out  1  PLRU init sweep active

Behaviour:
- Single clock (clk). Synchronous active-high reset (rst).
- Reset: FSM to INIT, init counter = 0, skid empty. All outputs are 0 except init_busy_o = 1.
- FSM INIT: writes 0 to PLRU[cnt] each cycle and increments cnt. At cnt == SETS-1 it transitions to RUN (SETS cycles total). d3_rdy_o = 0 throughout INIT.
- FSM RUN: remains in RUN until rst.
- Reset mid-operation: all in-flight entries are dropped; dp_vld_o and tw_vld_o are 0 the next cycle; INIT restarts.
- Accept = d3_vld_i & d3_rdy_o.
- d3_rdy_o = RUN & ~skid_full, where skid_full is registered.
- Latency: 1 cycle from accept to dp_vld_o when the output register is empty or draining.
- Output register holds while dp_vld_o & ~dp_rdy_i. A new accept during a stall goes to the skid entry. Skid refills the output register when it drains. Order is strictly preserved.
- Way select is combinational at accept:
  - hit_vec != 0: way = lowest set bit, hit = 1, evict = 0. err = (popcount(hit_vec) > 1).
  - miss & alloc & any invalid way: way = lowest invalid, evict = 0.
  - miss & alloc & all ways valid: way = PLRU victim, evict = 1.
  - miss & ~alloc: way = 0, hit = 0, evict = 0, no PLRU update, no tag write.
- Tree PLRU: WAYS-1 bits per set, heap-ordered with node 0 as root.
  - Bit = 0 means the victim is in the lower subtree.
  - On access, each node on the path is set to point away from the accessed way.
  - Updated on accept for hits and allocating misses.
  - Table is flop-based, read combinationally by d3_set_i. Back-to-back same-set accepts see the updated bits; no bypass is required.
- Tag write: tw_vld_o pulses exactly 1 cycle after accept of an allocating miss, independent of dp backpressure. tw_* fields hold their values otherwise.

Decomposition:
- Package scr_base_l3_bk_pkg holds: the d4 request struct typedef (id, set, way, hit, evict, err), the WAYS/SETS defaults, and the tp_d4 FSM state enum (INIT, RUN).
- Sub-module scr_base_l3_plru_tree: combinational victim encode plus update-vector logic, parameterised by WAYS.

Test Plan:
All scenarios use WAYS=4, SETS=16.
1. Hold rst 2 cycles, then release -> init_busy_o = 1 and d3_rdy_o = 0 for exactly 16 cycles, then d3_rdy_o = 1; all dp/tw outputs stay 0 throughout.
2. Set 3, hit_vec = 4'b0100 -> next cycle dp_vld_o = 1, way = 2, hit = 1, evict = 0, err = 0, tw_vld_o = 0.
3. Set 5, way_vld = 4'b1111, three consecutive allocating misses -> ways 0, 2, 1 in order, each with evict = 1 and a tw_vld_o pulse carrying the matching way and tag.
4. way_vld = 4'b1011, allocating miss -> way = 2, evict = 0, tw_way_o = 2. Separately, hit_vec = 4'b0110 -> way = 1, err = 1.
5. dp_rdy_i = 0, drive 3 requests -> first 2 accepted, then d3_rdy_o = 0. Raise dp_rdy_i -> ids emerge in issue order, the third request is accepted, and nothing is lost or duplicated.
6. Assert rst while dp_vld_o = 1 with the skid full -> next cycle dp_vld_o = 0, init_busy_o = 1, and the INIT sweep restarts from set 0.
